// File: rtl/cpu_pkg.sv
// Shared opcode map, sequencer state encoding and opcode-class helpers
// for the 16-bit processor control path.
package cpu_pkg;

  localparam logic [3:0] OP_JMP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_SHL = 4'h6;
  localparam logic [3:0] OP_SHR = 4'h7;
  localparam logic [3:0] OP_MOV = 4'h8;
  localparam logic [3:0] OP_LD  = 4'h9;
  localparam logic [3:0] OP_ST  = 4'hA;
  localparam logic [3:0] OP_BEQ = 4'hB;
  localparam logic [3:0] OP_BNE = 4'hC;
  localparam logic [3:0] OP_BLT = 4'hD;
  localparam logic [3:0] OP_BGE = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Same set the decoder uses to select the immediate as the PC target
  function automatic logic is_branch(input logic [3:0] op);
    return (op == OP_JMP) || ((op >= OP_BEQ) && (op <= OP_BGE));
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolution: decides whether a JMP/Bcc redirects
// the PC given the current ALU flags.
module branch_cond_eval
  import cpu_pkg::*;
(
  input  logic [3:0] op_i,
  input  logic       z_i,
  input  logic       n_i,
  input  logic       v_i,
  output logic       taken_o
);

  // Condition select by opcode; non-branch opcodes never redirect
  always_comb begin
    taken_o = 1'b0;
    case (op_i)
      OP_JMP:  taken_o = 1'b1;
      OP_BEQ:  taken_o = z_i;
      OP_BNE:  taken_o = ~z_i;
      OP_BLT:  taken_o = n_i ^ v_i;
      OP_BGE:  taken_o = ~(n_i ^ v_i);
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: owns the memory port and
// issues the IR/PC/register-file/flag strobes for the datapath.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] op,
  input  logic       flag_en,
  input  logic       z,
  input  logic       n,
  input  logic       v,
  input  logic       mem_rdy,
  input  logic       resume,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       rf_we,
  output logic       wb_sel,
  output logic       flag_we,
  output logic       halted,
  output logic       bus_err,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(WAIT_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
  logic             cnt_step_s;
  logic             taken_s;
  logic             mem_req_s, mem_we_s, addr_sel_s, ir_load_s, pc_inc_s;
  logic             pc_load_s, rf_we_s, wb_sel_s, flag_we_s, halted_s;

  branch_cond_eval u_branch_cond_eval (
    .op_i    (op),
    .z_i     (z),
    .n_i     (n),
    .v_i     (v),
    .taken_o (taken_s)
  );

  // Next-state, wait-counter and bus-error logic
  always_comb begin
    state_d    = state_q;
    bus_err_d  = bus_err_q;
    cnt_step_s = 1'b0;
    case (state_q)
      ST_FETCH, ST_MEM: begin
        if (mem_rdy) begin
          if (state_q == ST_FETCH) begin
            state_d = ST_DECODE;
          end else if (op == OP_LD) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (cnt_q == WAIT_LIM) begin
          state_d   = ST_HALT;
          bus_err_d = 1'b1;
        end else begin
          cnt_step_s = 1'b1;
        end
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        if ((op == OP_LD) || (op == OP_ST)) begin
          state_d = ST_MEM;
        end else if (op == OP_HLT) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_WB: state_d = ST_FETCH;
      ST_HALT: begin
        if (resume) begin
          state_d   = ST_FETCH;
          bus_err_d = 1'b0;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_HALT;
    endcase
    // Every state change restarts the timeout window
    cnt_d = (state_d != state_q) ? '0 :
            (cnt_step_s ? (cnt_q + CNT_W'(1)) : cnt_q);
  end

  // State, wait counter and sticky bus error
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Strobe decode from current state, opcode, flags and memory ready
  always_comb begin
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    addr_sel_s = 1'b0;
    ir_load_s  = 1'b0;
    pc_inc_s   = 1'b0;
    pc_load_s  = 1'b0;
    rf_we_s    = 1'b0;
    wb_sel_s   = 1'b0;
    flag_we_s  = 1'b0;
    halted_s   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        ir_load_s = mem_rdy;
        pc_inc_s  = mem_rdy;
      end
      ST_EXEC: begin
        if (is_alu(op)) begin
          rf_we_s   = 1'b1;
          flag_we_s = flag_en;
        end else if (is_branch(op)) begin
          pc_load_s = taken_s;
        end else begin
          pc_load_s = 1'b0;
        end
      end
      ST_MEM: begin
        mem_req_s  = 1'b1;
        addr_sel_s = 1'b1;
        mem_we_s   = (op == OP_ST);
      end
      ST_WB: begin
        rf_we_s  = 1'b1;
        wb_sel_s = 1'b1;
      end
      ST_HALT:   halted_s = 1'b1;
      ST_DECODE: halted_s = 1'b0;
      default:   halted_s = 1'b0;
    endcase
  end

  // Reset gates the strobes directly so an in-flight access dies without a clock
  assign mem_req  = mem_req_s  & ~reset;
  assign mem_we   = mem_we_s   & ~reset;
  assign addr_sel = addr_sel_s & ~reset;
  assign ir_load  = ir_load_s  & ~reset;
  assign pc_inc   = pc_inc_s   & ~reset;
  assign pc_load  = pc_load_s  & ~reset;
  assign rf_we    = rf_we_s    & ~reset;
  assign wb_sel   = wb_sel_s   & ~reset;
  assign flag_we  = flag_we_s  & ~reset;
  assign halted   = halted_s   & ~reset;
  assign bus_err  = bus_err_q;
  assign state    = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer: one vector per cycle,
// expected state and strobe set written out by hand.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic       flag_en, z, n, v, mem_rdy, resume;
  logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
  logic       rf_we, wb_sel, flag_we, halted, bus_err;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  localparam logic [10:0] B_NONE = 11'h000;
  localparam logic [10:0] B_REQ  = 11'h400;
  localparam logic [10:0] B_WE   = 11'h200;
  localparam logic [10:0] B_AS   = 11'h100;
  localparam logic [10:0] B_IR   = 11'h080;
  localparam logic [10:0] B_PCI  = 11'h040;
  localparam logic [10:0] B_PCL  = 11'h020;
  localparam logic [10:0] B_RF   = 11'h010;
  localparam logic [10:0] B_WB   = 11'h008;
  localparam logic [10:0] B_FW   = 11'h004;
  localparam logic [10:0] B_HLT  = 11'h002;
  localparam logic [10:0] B_BE   = 11'h001;
  localparam logic [10:0] B_FETCH_OK = 11'h4C0;

  logic [10:0] strobes_s;
  assign strobes_s = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load,
                      rf_we, wb_sel, flag_we, halted, bus_err};

  control_sequencer #(.WAIT_MAX(15), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .flag_en(flag_en),
    .z(z), .n(n), .v(v), .mem_rdy(mem_rdy), .resume(resume),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel),
    .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
    .rf_we(rf_we), .wb_sel(wb_sel), .flag_we(flag_we),
    .halted(halted), .bus_err(bus_err), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Caller sits on a falling edge with inputs already set; check then advance
  task automatic cyc(input string tag, input logic [2:0] exp_st,
                     input logic [10:0] exp_str);
    #1;
    check_eq({tag, "_state"}, {29'd0, state}, {29'd0, exp_st});
    check_eq({tag, "_strb"}, {21'd0, strobes_s}, {21'd0, exp_str});
    @(negedge clk);
  endtask

  task automatic instr3(input string tag, input logic [3:0] opc,
                        input logic [10:0] exec_str);
    op = opc;
    cyc({tag, "_f"}, 3'd0, B_FETCH_OK);
    cyc({tag, "_d"}, 3'd1, B_NONE);
    cyc({tag, "_x"}, 3'd2, exec_str);
  endtask

  initial begin
    reset = 1'b1; op = 4'h1; flag_en = 1'b1; z = 1'b0; n = 1'b0; v = 1'b0;
    mem_rdy = 1'b1; resume = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_state", {29'd0, state}, 32'd0);
    check_eq("rst_strb", {21'd0, strobes_s}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // ALU ops and branches with zero-wait memory
    instr3("add_fe", 4'h1, B_RF | B_FW);
    flag_en = 1'b0;
    instr3("sub_nofe", 4'h2, B_RF);
    resume = 1'b1;
    instr3("mov_resume_ign", 4'h8, B_RF);
    resume = 1'b0;
    instr3("jmp", 4'h0, B_PCL);
    z = 1'b1;
    instr3("beq_z1", 4'hB, B_PCL);
    instr3("bne_z1", 4'hC, B_NONE);
    z = 1'b0; n = 1'b1; v = 1'b0;
    instr3("blt_n1v0", 4'hD, B_PCL);
    instr3("bge_n1v0", 4'hE, B_NONE);
    n = 1'b1; v = 1'b1;
    instr3("bge_n1v1", 4'hE, B_PCL);
    z = 1'b0;
    instr3("bne_z0", 4'hC, B_PCL);

    // LD with three wait cycles in MEM
    instr3("ld", 4'h9, B_NONE);
    mem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) cyc("ld_memwait", 3'd3, B_REQ | B_AS);
    mem_rdy = 1'b1;
    cyc("ld_memdone", 3'd3, B_REQ | B_AS);
    cyc("ld_wb", 3'd4, B_RF | B_WB);

    // Zero-wait ST
    instr3("st", 4'hA, B_NONE);
    cyc("st_mem", 3'd3, B_REQ | B_AS | B_WE);

    // Fetch timeout: 16 request cycles (count 0..15), then HALT with bus_err
    mem_rdy = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to_fetch", 3'd0, B_REQ);
    cyc("to_halt", 3'd5, B_HLT | B_BE);
    cyc("to_halt2", 3'd5, B_HLT | B_BE);
    resume = 1'b1;
    cyc("to_resume", 3'd5, B_HLT | B_BE);
    resume = 1'b0;
    cyc("to_refetch", 3'd0, B_REQ);
    mem_rdy = 1'b1;

    // Ready arriving exactly when the count hits the limit completes normally
    instr3("ld_edge", 4'h9, B_NONE);
    mem_rdy = 1'b0;
    for (int i = 0; i < 15; i++) cyc("edge_wait", 3'd3, B_REQ | B_AS);
    mem_rdy = 1'b1;
    cyc("edge_done", 3'd3, B_REQ | B_AS);
    cyc("edge_wb", 3'd4, B_RF | B_WB);

    // HLT: idle with no strobes until resume
    instr3("hlt", 4'hF, B_NONE);
    for (int i = 0; i < 10; i++) cyc("hlt_idle", 3'd5, B_HLT);
    resume = 1'b1;
    cyc("hlt_resume", 3'd5, B_HLT);
    resume = 1'b0;

    // Reset in the middle of a ST memory access
    instr3("st_rst", 4'hA, B_NONE);
    mem_rdy = 1'b0;
    cyc("st_rst_mem", 3'd3, B_REQ | B_AS | B_WE);
    #1;
    check_eq("st_rst_pre_we", {31'd0, mem_we}, 32'd1);
    reset = 1'b1;
    #1;
    check_eq("async_req", {31'd0, mem_req}, 32'd0);
    check_eq("async_we", {31'd0, mem_we}, 32'd0);
    check_eq("async_state", {29'd0, state}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    mem_rdy = 1'b1;
    cyc("post_rst", 3'd0, B_FETCH_OK);
    cyc("post_rst_d", 3'd1, B_NONE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute FSM for the 16-bit processor.
- Consumes the opcode and flag-enable fields from the instruction decoder and the ALU status flags.
- Drives the IR load, PC update, memory request handshake, register-file write and flag-register write strobes.
- Sits between the instruction decoder and the datapath/memory interface. Sole owner of the memory port, with instruction and data accesses serialised.

Parameters:
- WAIT_MAX, 15: maximum cycles mem_req may stay asserted without mem_rdy before a bus error is raised.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > WAIT_MAX.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  4  opcode field (instr[15:12]) from the instruction decoder
- flag_en  in  1  instr[1]: update flags on ALU ops
- z, n, v  in  1 each  ALU flag register outputs (zero, negative, overflow)
- mem_rdy  in  1  memory completes the current request this cycle
- resume  in  1  leave HALT (one-cycle pulse)
- mem_req  out  1  memory request
- mem_we  out  1  write strobe, qualified by mem_req
- addr_sel  out  1  address mux: 0 = PC, 1 = ALU result
- ir_load  out  1  capture memory read data into IR
- pc_inc  out  1  PC <= PC + 1
- pc_load  out  1  PC <= branch target (immediate path)
- rf_we  out  1  register-file write enable
- wb_sel  out  1  writeback mux: 0 = ALU, 1 = memory data
- flag_we  out  1  flag-register write enable
- halted  out  1  high in HALT
- bus_err  out  1  sticky memory timeout error
- state  out  3  current state, for debug

Behaviour:
- Opcode map:
  - 0000 JMP; 0001–1000 ALU ops; 1001 LD; 1010 ST.
  - 1011 BEQ (z); 1100 BNE (!z); 1101 BLT (n^v); 1110 BGE (!(n^v)).
  - 1111 HLT.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5. Codes 6 and 7 are illegal and go to HALT.
- State register, wait counter and bus_err reset asynchronously to FETCH/0/0. All strobe outputs are Moore/combinational from state plus inputs and are 0 while reset is high.
- FETCH:
  - Drives mem_req=1, addr_sel=0.
  - On mem_rdy: ir_load=1 and pc_inc=1 for exactly that cycle, then go to DECODE.
  - Otherwise stay in FETCH and increment the wait counter.
- DECODE: one cycle, no strobes (register-file read settle), then EXEC.
- EXEC, single cycle, always exits. Action by op:
  - ALU: rf_we=1, wb_sel=0, flag_we=flag_en, then FETCH.
  - JMP: pc_load=1, then FETCH.
  - Conditional branch: pc_load=1 only if the condition is true, then FETCH.
  - LD/ST: MEM.
  - HLT: HALT.
- MEM:
  - Drives mem_req=1, addr_sel=1, mem_we=1 for ST.
  - On mem_rdy: LD goes to WB; ST goes to FETCH.
  - Otherwise wait and count.
- WB: rf_we=1, wb_sel=1, then FETCH.
- HALT:
  - halted=1, no strobes.
  - resume=1 goes to FETCH and clears bus_err and the counter.
  - resume is ignored in every other state.
- Wait counter:
  - Clears on every state entry.
  - While mem_req=1 and mem_rdy=0 it increments. When it reaches WAIT_MAX with mem_rdy still 0: set bus_err, drop the request, go to HALT.
  - mem_rdy in the same cycle the count reaches WAIT_MAX wins (normal completion).
- Flags are sampled combinationally in EXEC. The flags value seen there reflects the previous flag-setting instruction.
- CPI with zero-wait memory (mem_rdy tied high): ALU/branch 3, ST 4, LD 5.
- Reset mid-access: mem_req drops immediately (asynchronously). No partial IR, PC or register-file update occurs.

Decomposition:
- Shared package cpu_pkg:
  - Opcode localparams (OP_JMP, OP_ADD … OP_HLT).
  - State encodings.
  - Helper function is_branch(op), matching the decoder's immediate-select set {0000, 1011–1110}.
- One natural sub-module: branch_cond_eval (op, z, n, v -> taken), a combinational unit reused by verification.

Test Plan:
- Reset released, mem_rdy=1, ADD op=0001 with flag_en=1 -> states 0,1,2,0. ir_load and pc_inc pulse in cycle 0; rf_we and flag_we in cycle 2. Strobes are 0 in all other cycles.
- Branches with flags z=1 -> BEQ (1011) gives pc_load=1 in EXEC; BNE (1100) gives pc_load=0.
- Signed branches with n=1, v=0 -> BLT (1101) taken, BGE (1110) not taken.
- LD with mem_rdy low for 3 cycles in MEM -> mem_req and addr_sel=1 held for 4 cycles, then WB with rf_we=1 and wb_sel=1. ST produces mem_we=1 only in MEM.
- mem_rdy held low in FETCH with WAIT_MAX=15 -> bus_err=1 and HALT after the count reaches 15. A resume pulse then returns to FETCH with bus_err=0.
- HLT (1111) -> halted=1 and no strobes for 10 cycles. Reset asserted mid-MEM of a ST -> mem_req and mem_we fall without waiting for a clock, and the FSM restarts in FETCH.
